// File: rtl/video_pattern_checker.sv
// Checks a received test pattern against the locally generated one and tracks frame lock.
// Optional frame CRC output is enabled by defining VIDEO_CHECK_CRC_EN.
module video_pattern_checker #(
  parameter int unsigned COORDSPC    = 16,
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned ERRW        = 24
) (
  input  logic                       video_clk_pix,
  input  logic                       video_rst,
  input  logic                       video_enable,
  input  logic                       frame_start,
  input  logic                       line_start,
  input  logic signed [COORDSPC-1:0] sx,
  input  logic signed [COORDSPC-1:0] sy,
  input  logic [9:0]                 red,
  input  logic [9:0]                 green,
  input  logic [9:0]                 blue,
  output logic                       frame_done,
  output logic [ERRW-1:0]            last_err_count,
  output logic [ERRW-1:0]            last_pix_count,
  output logic                       frame_ok,
  output logic                       locked,
  output logic                       lock_lost,
  output logic [1:0]                 state,
`ifdef VIDEO_CHECK_CRC_EN
  output logic [15:0]                frame_crc,
`endif
  output logic signed [COORDSPC-1:0] first_err_x,
  output logic signed [COORDSPC-1:0] first_err_y
);

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StCheck   = 2'd1,
    StLocked  = 2'd2,
    StInvalid = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [7:0] clean_q, clean_d, clean_inc;

  logic signed [COORDSPC-1:0] d_sx_q, d_sy_q;
  logic                       d_en_q, d_fs_q;

  logic [ERRW-1:0] pix_acc_q, pix_acc_d, pix_base;
  logic [ERRW-1:0] err_acc_q, err_acc_d, err_base;
  logic            seen_q, seen_d, seen_base;
  logic signed [COORDSPC-1:0] fx_acc_q, fx_acc_d, fy_acc_q, fy_acc_d;

  logic                       done_q, ok_q, lost_q, lost_d, publish, frame_clean;
  logic [ERRW-1:0]            last_err_q, last_pix_q;
  logic signed [COORDSPC-1:0] first_x_q, first_y_q;

  logic [9:0] px, py, exp_r, exp_g, exp_b;
  logic       white, avoid, mismatch;

  logic unused_line_start;
  assign unused_line_start = line_start;

  // Expected pattern for the pixel whose coordinates were registered last cycle.
  assign px = d_sx_q[9:0];
  assign py = d_sy_q[9:0];

  always_comb begin
    white = (px[7:0] == py[7:0]);
    avoid = (px[7:5] == 3'd2) && (py[7:5] == 3'd2);
    exp_r = ((py[4:3] == ~px[4:3]) ? {px[5:0], 4'b0000} : 10'd0);
    exp_g = (py[6] ? px : 10'd0);
    exp_r = (exp_r | {10{white}}) & ~{10{avoid}};
    exp_g = (exp_g | {10{white}}) & ~{10{avoid}};
    exp_b = py | {10{white}} | {10{avoid}};
    mismatch = d_en_q && ({red, green, blue} != {exp_r, exp_g, exp_b});
  end

  // The frame-start pixel opens the new frame, so accumulation restarts from it.
  always_comb begin
    pix_base  = d_fs_q ? '0 : pix_acc_q;
    err_base  = d_fs_q ? '0 : err_acc_q;
    seen_base = d_fs_q ? 1'b0 : seen_q;
    pix_acc_d = pix_base;
    err_acc_d = err_base;
    if (d_en_q && (pix_base != {ERRW{1'b1}})) pix_acc_d = pix_base + ERRW'(1);
    if (mismatch && (err_base != {ERRW{1'b1}})) err_acc_d = err_base + ERRW'(1);
    seen_d   = seen_base | mismatch;
    fx_acc_d = d_fs_q ? '0 : fx_acc_q;
    fy_acc_d = d_fs_q ? '0 : fy_acc_q;
    if (mismatch && !seen_base) begin
      fx_acc_d = d_sx_q;
      fy_acc_d = d_sy_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    clean_d     = clean_q;
    publish     = 1'b0;
    lost_d      = 1'b0;
    clean_inc   = clean_q + 8'd1;
    frame_clean = (err_acc_q == '0) && (pix_acc_q != '0);
    case (state_q)
      StSearch: begin
        if (d_fs_q) begin
          state_d = StCheck;
          clean_d = 8'd0;
        end
      end
      StCheck: begin
        if (d_fs_q) begin
          publish = 1'b1;
          if (frame_clean) begin
            clean_d = clean_inc;
            if (clean_inc >= 8'(LOCK_FRAMES)) state_d = StLocked;
          end else begin
            clean_d = 8'd0;
          end
        end
      end
      StLocked: begin
        if (d_fs_q) begin
          publish = 1'b1;
          if (!frame_clean) begin
            state_d = StCheck;
            clean_d = 8'd0;
            lost_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StSearch;
        clean_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      state_q    <= StSearch;
      clean_q    <= 8'd0;
      d_sx_q     <= '0;
      d_sy_q     <= '0;
      d_en_q     <= 1'b0;
      d_fs_q     <= 1'b0;
      pix_acc_q  <= '0;
      err_acc_q  <= '0;
      seen_q     <= 1'b0;
      fx_acc_q   <= '0;
      fy_acc_q   <= '0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      lost_q     <= 1'b0;
      last_err_q <= '0;
      last_pix_q <= '0;
      first_x_q  <= '0;
      first_y_q  <= '0;
    end else begin
      state_q   <= state_d;
      clean_q   <= clean_d;
      d_sx_q    <= sx;
      d_sy_q    <= sy;
      d_en_q    <= video_enable;
      d_fs_q    <= frame_start;
      pix_acc_q <= pix_acc_d;
      err_acc_q <= err_acc_d;
      seen_q    <= seen_d;
      fx_acc_q  <= fx_acc_d;
      fy_acc_q  <= fy_acc_d;
      done_q    <= publish;
      lost_q    <= lost_d;
      if (publish) begin
        last_err_q <= err_acc_q;
        last_pix_q <= pix_acc_q;
        ok_q       <= frame_clean;
        first_x_q  <= fx_acc_q;
        first_y_q  <= fy_acc_q;
      end
    end
  end

`ifdef VIDEO_CHECK_CRC_EN
  // CRC-16-CCITT over {red, green, blue}, MSB first.
  function automatic logic [15:0] crc16_30(input logic [15:0] crc_in, input logic [29:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 29; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  logic [15:0] crc_acc_q, crc_acc_d, crc_base, crc_q;

  always_comb begin
    crc_base  = d_fs_q ? 16'hFFFF : crc_acc_q;
    crc_acc_d = d_en_q ? crc16_30(crc_base, {red, green, blue}) : crc_base;
  end

  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      crc_acc_q <= 16'd0;
      crc_q     <= 16'd0;
    end else begin
      crc_acc_q <= crc_acc_d;
      if (publish) crc_q <= crc_acc_q;
    end
  end

  assign frame_crc = crc_q;
`endif

  assign frame_done     = done_q;
  assign last_err_count = last_err_q;
  assign last_pix_count = last_pix_q;
  assign frame_ok       = ok_q;
  assign lock_lost      = lost_q;
  assign first_err_x    = first_x_q;
  assign first_err_y    = first_y_q;
  assign state          = state_q;
  assign locked         = (state_q == StLocked);

endmodule

// File: tb/tb_video_pattern_checker.sv
// Randomised bench for video_pattern_checker against a frame-level reference model.
module tb_video_pattern_checker;
  localparam int unsigned CW = 16;
  localparam int unsigned LF = 4;
  localparam int unsigned EW = 8;
  localparam int HB = 4;
  localparam int MAXC = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst, en, fs, ls;
  logic signed [CW-1:0] sx, sy;
  logic [9:0] red, green, blue;
  logic frame_done, frame_ok, locked, lock_lost;
  logic [EW-1:0] last_err_count, last_pix_count;
  logic [1:0] state;
  logic signed [CW-1:0] first_err_x, first_err_y;
`ifdef VIDEO_CHECK_CRC_EN
  logic [15:0] frame_crc;
`endif

  video_pattern_checker #(.COORDSPC(CW), .LOCK_FRAMES(LF), .ERRW(EW)) dut (
    .video_clk_pix (clk),
    .video_rst     (rst),
    .video_enable  (en),
    .frame_start   (fs),
    .line_start    (ls),
    .sx            (sx),
    .sy            (sy),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .frame_done    (frame_done),
    .last_err_count(last_err_count),
    .last_pix_count(last_pix_count),
    .frame_ok      (frame_ok),
    .locked        (locked),
    .lock_lost     (lock_lost),
    .state         (state),
`ifdef VIDEO_CHECK_CRC_EN
    .frame_crc     (frame_crc),
`endif
    .first_err_x   (first_err_x),
    .first_err_y   (first_err_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  // Pattern rules in plain arithmetic on the low 10 bits of the coordinates.
  function automatic logic [29:0] exp_color(input logic [15:0] x, input logic [15:0] y);
    int xv, yv, rr, gg, bb;
    bit w, a;
    xv = int'(x) & 1023;
    yv = int'(y) & 1023;
    w  = (xv % 256) == (yv % 256);
    a  = ((xv / 32) % 8 == 2) && ((yv / 32) % 8 == 2);
    rr = (((yv / 8) % 4) == (3 - (xv / 8) % 4)) ? (xv % 64) * 16 : 0;
    gg = ((yv / 64) % 2 == 1) ? xv : 0;
    bb = yv;
    if (w) begin rr = 1023; gg = 1023; bb = 1023; end
    if (a) begin rr = 0; gg = 0; bb = 1023; end
    return {rr[9:0], gg[9:0], bb[9:0]};
  endfunction

  function automatic logic [15:0] crc30(input logic [15:0] c, input logic [29:0] d);
    logic [15:0] r;
    bit fb;
    r = c;
    for (int i = 29; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  typedef struct {
    int idx; bit fs; bit en; bit err; logic [15:0] x; logic [15:0] y; logic [29:0] pix;
  } ev_t;

  typedef struct {
    int at_edge; int kind; int st; int pix; int err; bit ok;
    logic [15:0] fx; logic [15:0] fy; bit lost; logic [15:0] crc;
  } rec_t;

  rec_t q[$];

  // Reference model state
  bit armed = 0, lk = 0, have_first = 0;
  int cnt = 0, acc_pix = 0, acc_err = 0;
  logic [15:0] mfx = 0, mfy = 0, mcrc = 16'hFFFF;
  ev_t prev;
  bit prev_valid = 0;

  task automatic model_event(input ev_t e);
    rec_t r;
    bit ok;
    if (e.fs) begin
      r = '{at_edge: e.idx + 2, kind: 0, st: 1, pix: 0, err: 0, ok: 0, fx: 0, fy: 0,
            lost: 0, crc: 0};
      if (armed) begin
        ok = (acc_err == 0) && (acc_pix > 0);
        if (lk) begin
          if (!ok) begin lk = 0; cnt = 0; r.lost = 1; end
        end else if (ok) begin
          cnt++;
          if (cnt >= LF) lk = 1;
        end else begin
          cnt = 0;
        end
        r.kind = 1; r.st = lk ? 2 : 1; r.pix = acc_pix; r.err = acc_err; r.ok = ok;
        r.fx = mfx; r.fy = mfy; r.crc = mcrc;
      end else begin
        armed = 1; cnt = 0;
      end
      q.push_back(r);
      acc_pix = 0; acc_err = 0; have_first = 0; mfx = 0; mfy = 0; mcrc = 16'hFFFF;
    end
    if (e.en) begin
      if (acc_pix < MAXC) acc_pix++;
      mcrc = crc30(mcrc, e.pix);
    end
    if (e.err) begin
      if (acc_err < MAXC) acc_err++;
      if (!have_first) begin have_first = 1; mfx = e.x; mfy = e.y; end
    end
  endtask

  // One pixel clock: coordinates for this pixel, colours for the previous one.
  task automatic step(input bit fs_i, input bit en_i, input logic [15:0] x, input logic [15:0] y,
                      input logic [29:0] corrupt, input bit do_rst);
    ev_t cur;
    rec_t r;
    @(posedge clk);
    #1;
    if (prev_valid) {red, green, blue} = prev.pix;
    else {red, green, blue} = 30'($urandom);
    sx = x; sy = y; en = en_i; fs = fs_i; rst = do_rst; ls = 1'b0;
    cur.idx = cyc; cur.fs = fs_i; cur.en = en_i; cur.x = x; cur.y = y;
    cur.err = en_i && (corrupt != 30'd0);
    cur.pix = en_i ? (exp_color(x, y) ^ corrupt) : 30'($urandom);
    if (do_rst) begin
      prev_valid = 0;
      armed = 0; lk = 0; cnt = 0;
      r = '{at_edge: cyc + 1, kind: 2, st: 0, pix: 0, err: 0, ok: 0, fx: 0, fy: 0,
            lost: 0, crc: 0};
      q.push_back(r);
    end else begin
      if (prev_valid) model_event(prev);
      prev = cur;
      prev_valid = 1;
    end
  endtask

  // mode: 0 clean, 1 ncorr spread errors, 2 all corrupt, 3 video_enable low
  task automatic frame(input logic [15:0] x0, input logic [15:0] y0, input int w, input int h,
                       input int mode, input int ncorr, input int off, input logic [29:0] mask,
                       input int rst_at);
    int n, a, stride;
    bit act, bad;
    logic [29:0] m;
    n = 0; a = 0;
    stride = (ncorr > 0) ? (w * h) / ncorr : 1;
    for (int row = 0; row < h; row++) begin
      for (int col = 0; col < w + HB; col++) begin
        act = (col < w) && (mode != 3);
        m = 30'd0;
        if (col < w) begin
          bad = (mode == 2) ||
                (mode == 1 && a >= off && ((a - off) % stride) == 0 && ((a - off) / stride) < ncorr);
          if (bad) begin
            m = (mask != 30'd0) ? mask : 30'($urandom);
            if (m == 30'd0) m = 30'd1;
          end
          a++;
        end
        step(row == 0 && col == 0, act, 16'(x0 + 16'(col)), 16'(y0 + 16'(row)), m, n == rst_at);
        n++;
      end
    end
  endtask

  task automatic short_frame();
    frame(16'($urandom), 16'($urandom), 4, 1, 0, 0, 0, 30'd0, -1);
  endtask

  // Compare process: every cycle once reset has been applied.
  logic [1:0] e_state = 0;
  int e_pix = 0, e_err = 0, done_edge = -1, lost_edge = -1;
  bit e_ok = 0;
  logic [15:0] e_fx = 0, e_fy = 0, e_crc = 0;
  rec_t hr;

  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].at_edge <= cyc) begin
        hr = q.pop_front();
        if (hr.kind == 2) begin
          e_state = 0; e_pix = 0; e_err = 0; e_ok = 0; e_fx = 0; e_fy = 0; e_crc = 0;
          done_edge = -1; lost_edge = -1;
        end else if (hr.kind == 0) begin
          e_state = 2'(hr.st);
        end else begin
          e_state = 2'(hr.st); e_pix = hr.pix; e_err = hr.err; e_ok = hr.ok;
          e_fx = hr.fx; e_fy = hr.fy; e_crc = hr.crc;
          done_edge = hr.at_edge;
          lost_edge = hr.lost ? hr.at_edge : -1;
        end
      end
      if (cmp_en) begin
        chk("frame_done", 32'(frame_done), 32'(done_edge == cyc));
        chk("lock_lost", 32'(lock_lost), 32'(lost_edge == cyc));
        chk("state", 32'(state), 32'(e_state));
        chk("locked", 32'(locked), 32'(e_state == 2'd2));
        chk("frame_ok", 32'(frame_ok), 32'(e_ok));
        chk("last_pix_count", 32'(last_pix_count), 32'(e_pix));
        chk("last_err_count", 32'(last_err_count), 32'(e_err));
        chk("first_err_x", {16'b0, first_err_x}, {16'b0, e_fx});
        chk("first_err_y", {16'b0, first_err_y}, {16'b0, e_fy});
`ifdef VIDEO_CHECK_CRC_EN
        chk("frame_crc", {16'b0, frame_crc}, {16'b0, e_crc});
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int w, h, md, om, nc, ra, total;
  logic [15:0] x0, y0;

  initial begin
    rst = 1; en = 0; fs = 0; ls = 0; sx = 0; sy = 0; red = 0; green = 0; blue = 0;
    @(posedge clk);
    #1;
    cmp_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lit_reset_state", 32'(state), 32'd0);
    chk("lit_reset_done", 32'(frame_done), 32'd0);
    chk("lit_color_64_64", 32'(exp_color(16'd64, 16'd64)), 32'h3FF);
    chk("lit_color_10_0", 32'(exp_color(16'd10, 16'd0)), 32'd0);

    // Five clean frames from reset: four results published, lock on the fourth.
    for (int i = 0; i < 5; i++) frame(16'($urandom), 16'($urandom), 16, 8, 0, 0, 0, 30'd0, -1);
    short_frame();
    @(negedge clk);
    chk("lit_locked", 32'(locked), 32'd1);
    chk("lit_pix_128", 32'(last_pix_count), 32'd128);
    chk("lit_ok_clean", 32'(frame_ok), 32'd1);

    // Three corrupted pixels while locked.
    frame(16'($urandom), 16'($urandom), 16, 8, 1, 3, $urandom_range(0, 41), 30'd0, -1);
    short_frame();
    @(negedge clk);
    chk("lit_state_check", 32'(state), 32'd1);
    chk("lit_err_3", 32'(last_err_count), 32'd3);
    for (int i = 0; i < 4; i++) frame(16'($urandom), 16'($urandom), 16, 8, 0, 0, 0, 30'd0, -1);
    short_frame();
    @(negedge clk);
    chk("lit_relocked", 32'(locked), 32'd1);

    // Blue LSB flipped at (10,0).
    frame(16'd10, 16'd0, 8, 2, 1, 1, 0, 30'd1, -1);
    short_frame();
    @(negedge clk);
    chk("lit_err_1", 32'(last_err_count), 32'd1);
    chk("lit_first_x", {16'b0, first_err_x}, 32'd10);
    chk("lit_first_y", {16'b0, first_err_y}, 32'd0);
    chk("lit_ok_bad", 32'(frame_ok), 32'd0);

    // Whole frame with video_enable low.
    frame(16'($urandom), 16'($urandom), 8, 2, 3, 0, 0, 30'd0, -1);
    short_frame();
    @(negedge clk);
    chk("lit_pix_0", 32'(last_pix_count), 32'd0);
    chk("lit_ok_empty", 32'(frame_ok), 32'd0);

    for (int f = 0; f < 40; f++) begin
      w = $urandom_range(6, 24);
      h = $urandom_range(2, 12);
      md = $urandom_range(0, 9);
      om = $urandom_range(0, 2);
      x0 = 16'($urandom);
      y0 = 16'($urandom);
      if (om == 1) y0 = x0;
      if (om == 2) begin
        x0 = 16'($urandom_range(56, 72));
        y0 = 16'($urandom_range(56, 72));
      end
      total = h * (w + HB);
      ra = ($urandom_range(0, 9) == 0) ? $urandom_range(1, total - 1) : -1;
      nc = $urandom_range(1, 4);
      if (md < 5) frame(x0, y0, w, h, 0, 0, 0, 30'd0, ra);
      else if (md < 8) frame(x0, y0, w, h, 1, nc, 0, 30'd0, ra);
      else if (md == 8) frame(x0, y0, w, h, 2, 0, 0, 30'd0, ra);
      else frame(x0, y0, w, h, 3, 0, 0, 30'd0, ra);
    end

    // Counter saturation: 288 active pixels, all corrupt.
    short_frame();
    frame(16'd0, 16'd0, 24, 12, 2, 0, 0, 30'd0, -1);
    short_frame();
    @(negedge clk);
    chk("lit_pix_sat", 32'(last_pix_count), 32'd255);
    chk("lit_err_sat", 32'(last_err_count), 32'd255);

    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'd0, 16'd0, 30'd0, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
